pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, pipelined successor to the 8-bit combinational barrel shifter. It shifts or rotates a WIDTH-bit word left or right by a runtime amount, in logical, arithmetic or rotate mode. It has one register stage per shift-amount bit and valid/ready flow control at both ends, so it can sit directly in a streaming datapath between a producer and a back-pressuring consumer.

## Interface
- WIDTH, 8, data width; power of two, ≥ 2.
- LOG2W, derived localparam = log2(WIDTH); number of pipeline stages (3 at default).
- AW, derived localparam = LOG2W+1; amount width (4 at default).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  WIDTH  word to shift.
- in_amt  in  AW  shift amount, 0..2·WIDTH−1.
- in_lr  in  1  direction: 1 = left, 0 = right.
- in_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted result.

## Operation
- Transfer occurs on any cycle with valid && ready at that port.
- Stage k (k = 0..LOG2W−1) conditionally shifts by 2^k according to bit k of the effective amount, then registers the word, the control fields and a valid bit.
- Amounts ≥ WIDTH (in_amt[AW−1] = 1), resolved in stage 0:
  - Logical: result is all zeros.
  - Arithmetic right: result is all copies of in_data[WIDTH−1].
  - Rotate: the effective amount is in_amt mod WIDTH; the MSB is ignored.
- Arithmetic left is identical to logical left.
- Fill rules: logical and arithmetic left fill with 0. Logical right fills with 0. Arithmetic right fills with the sign bit of the original in_data. Rotate re-inserts the bits shifted out.
- Amount 0 passes in_data unchanged in every mode and direction.
- Flow control is a global stall: stall = out_valid && !out_ready.
  - When stall is high, every stage holds, including its valid bit.
  - When stall is low, all stages advance together. Bubbles (invalid stages) advance but are not collapsed.
- in_ready = !stall, purely combinational from out_valid and out_ready.
- Results emerge in acceptance order. No word is dropped or duplicated.

## Timing
- Latency is LOG2W cycles: an input accepted at edge N produces out_valid at edge N+LOG2W, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput is one word per cycle while out_ready stays high.
- Reset: on the rst edge, all stage valid bits clear and out_valid = 0, out_data = 0. in_ready = 1 in the cycle after reset.
- Reset during operation discards all in-flight words. No stale word may appear after reset deasserts.
- An input presented while rst = 1 is not accepted.
- A word entering stage 0 and a word leaving the last stage in the same cycle is a normal advance; both transfers complete.
- While out_valid = 1 and out_ready = 0:
  - out_data must stay stable.
  - in_valid is ignored, because in_ready = 0.
- out_valid may rise while out_ready is low. The consumer may raise out_ready at any time.

## Test plan
- Basic modes, WIDTH=8, input 0x53, one word at a time:
  - Logical left by 1 → 0xA6.
  - Logical right by 2 → 0x14.
  - Rotate left by 3 → 0x9A.
  - Amount 0, both directions → 0x53.
  - Each result has out_valid exactly 3 cycles after acceptance.
- Arithmetic and saturation:
  - 0xA6 arithmetic right by 3 → 0xF4.
  - 0x80 arithmetic right by 12 → 0xFF.
  - 0x53 logical left by 8 → 0x00.
  - 0x53 rotate right by 9 → 0xA9.
- Streaming: 16 back-to-back words with random mode, direction and amount, out_ready held at 1 → one result per cycle, in order, all matching the reference model.
- Backpressure: push 4 words, then hold out_ready = 0 for 5 cycles:
  - in_ready drops as soon as out_valid rises.
  - out_data stays frozen during the stall.
  - After release, all 4 words arrive in order with none lost.
- Random out_ready toggling (50%) over 200 words → scoreboard shows no loss, duplication or reordering.
- Reset mid-operation: assert rst for 1 cycle while 3 words are in flight →
  - out_valid = 0 and out_data = 0 on the next cycle.
  - None of the 3 words ever appears.
  - The next accepted word returns correctly after 3 cycles.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Streams WIDTH-bit words through a log2(WIDTH)-deep shift pipeline.
//   Supports left/right logical, arithmetic and rotate shifts by a runtime amount.
//   A capture register sits in front of the shift stages, so a word accepted
//   at edge N is presented at edge N+LOG2W.
//   A global stall holds every rank while the output is valid and not taken.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake (in_ready = !stall)
//   in_data, in_amt        word and amount (0..2*WIDTH-1)
//   in_lr                  1 = left, 0 = right
//   in_mode                00 logical, 01 arithmetic, 10 rotate, 11 = logical
//   out_valid/out_ready    output handshake
//   out_data               shifted word

// One shift rank: conditionally shifts by 2^K, then registers word + controls.
module pbs_stage #(
  parameter int WIDTH = 8,
  parameter int LOG2W = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_word,
  input  logic [LOG2W-1:0] i_amt,
  input  logic             i_lr,
  input  logic [1:0]       i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_word,
  output logic [LOG2W-1:0] o_amt,
  output logic             o_lr,
  output logic [1:0]       o_mode,
  output logic             o_sign
);
  localparam int SH = 1 << K;

  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_fill;
  logic [WIDTH-1:0]   w_shift;

  // Doubled word: any WIDTH-wide window of it is a rotation.
  assign w_dbl  = {i_word, i_word};
  // Arithmetic right fills the vacated top bits with the original sign.
  assign w_fill = (i_mode == 2'b01 && i_sign) ? ~({WIDTH{1'b1}} >> SH) : {WIDTH{1'b0}};

  always_comb begin
    w_shift = i_word;
    if (i_amt[K]) begin
      if (i_mode == 2'b10)
        w_shift = i_lr ? w_dbl[2*WIDTH-1-SH -: WIDTH] : w_dbl[SH +: WIDTH];
      else if (i_lr)
        w_shift = i_word << SH;
      else
        w_shift = (i_word >> SH) | w_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_word <= '0;
      o_amt  <= '0;
      o_lr   <= 1'b0;
      o_mode <= 2'b00;
      o_sign <= 1'b0;
    end else if (en) begin
      o_word <= w_shift;
      o_amt  <= i_amt;
      o_lr   <= i_lr;
      o_mode <= i_mode;
      o_sign <= i_sign;
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH):0]   in_amt,
  input  logic                     in_lr,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int AW    = LOG2W + 1;

  // vld_pipe[0] = capture rank, vld_pipe[k+1] = shift stage k
  logic [LOG2W:0] vld_pipe;
  logic           w_stall;

  logic [WIDTH-1:0] r_c_data;
  logic [AW-1:0]    r_c_amt;
  logic             r_c_lr;
  logic [1:0]       r_c_mode;

  logic [1:0]       w_mode_n;
  logic             w_sat;
  logic [WIDTH-1:0] w_s0_word;
  logic [LOG2W-1:0] w_s0_amt;

  logic [LOG2W-1:0][WIDTH-1:0] w_st_word, r_st_word;
  logic [LOG2W-1:0][LOG2W-1:0] w_st_amt,  r_st_amt;
  logic [LOG2W-1:0][1:0]       w_st_mode, r_st_mode;
  logic [LOG2W-1:0]            w_st_lr,   r_st_lr;
  logic [LOG2W-1:0]            w_st_sign, r_st_sign;
  logic                        w_unused;

  assign w_stall   = vld_pipe[LOG2W] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = vld_pipe[LOG2W];
  assign out_data  = r_st_word[LOG2W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      r_c_data <= '0;
      r_c_amt  <= '0;
      r_c_lr   <= 1'b0;
      r_c_mode <= 2'b00;
    end else if (!w_stall) begin
      vld_pipe <= {vld_pipe[LOG2W-1:0], in_valid};
      r_c_data <= in_data;
      r_c_amt  <= in_amt;
      r_c_lr   <= in_lr;
      r_c_mode <= in_mode;
    end
  end

  // Amounts >= WIDTH are settled here: non-rotate modes saturate to the fill
  // pattern and the remaining stages see a zero amount; rotate drops the MSB.
  assign w_mode_n  = (r_c_mode == 2'b11) ? 2'b00 : r_c_mode;
  assign w_sat     = r_c_amt[AW-1] && (w_mode_n != 2'b10);
  assign w_s0_word = !w_sat ? r_c_data :
                     (w_mode_n == 2'b01 && !r_c_lr && r_c_data[WIDTH-1]) ?
                     {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign w_s0_amt  = w_sat ? '0 : r_c_amt[LOG2W-1:0];

  for (genvar k = 0; k < LOG2W; k++) begin : g_st
    if (k == 0) begin : g_first
      assign w_st_word[k] = w_s0_word;
      assign w_st_amt[k]  = w_s0_amt;
      assign w_st_lr[k]   = r_c_lr;
      assign w_st_mode[k] = w_mode_n;
      assign w_st_sign[k] = r_c_data[WIDTH-1];
    end else begin : g_rest
      assign w_st_word[k] = r_st_word[k-1];
      assign w_st_amt[k]  = r_st_amt[k-1];
      assign w_st_lr[k]   = r_st_lr[k-1];
      assign w_st_mode[k] = r_st_mode[k-1];
      assign w_st_sign[k] = r_st_sign[k-1];
    end

    pbs_stage #(.WIDTH(WIDTH), .LOG2W(LOG2W), .K(k)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (!w_stall),
      .i_word (w_st_word[k]),
      .i_amt  (w_st_amt[k]),
      .i_lr   (w_st_lr[k]),
      .i_mode (w_st_mode[k]),
      .i_sign (w_st_sign[k]),
      .o_word (r_st_word[k]),
      .o_amt  (r_st_amt[k]),
      .o_lr   (r_st_lr[k]),
      .o_mode (r_st_mode[k]),
      .o_sign (r_st_sign[k])
    );
  end

  // Last stage's control copies have no consumer.
  assign w_unused = ^{r_st_amt[LOG2W-1], r_st_lr[LOG2W-1],
                      r_st_mode[LOG2W-1], r_st_sign[LOG2W-1]};
endmodule
